mux_arbiter: RTL and testbench

Round-robin arbiter that shares a single 4-way data mux between four requesters and drives its select. Sits between independent producers and one downstream consumer: it picks a requester, holds the mux select for that requester's burst, and registers the muxed data into a valid/ready output stage. Replaces hand-driven `sel` stimulus with a sequenced, fair controller.

---
 rtl/mux_arbiter_if.sv | 24 ++
 rtl/mux_arbiter.sv | 113 +++++++++++
 tb/tb_mux_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mux_arbiter_if.sv
// Handshake/bus bundle between the four requesters, the mux arbiter and the consumer.
interface mux_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [3:0]         req;
    logic [3:0]         last;
    logic [4*WIDTH-1:0] din;
    logic [3:0]         gnt;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;

    // master: producers/consumer side; slave: the arbiter itself
    modport master (
        output req, last, din, out_ready,
        input  gnt, sel, out_data, out_valid
    );

    modport slave (
        input  req, last, din, out_ready,
        output gnt, sel, out_data, out_valid
    );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin arbiter driving a shared 4-way data mux into a valid/ready output register.
// Optional per-grant beat limit: define MUX_ARB_HOLD_LIMIT_EN.
module mux_arbiter #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_arbiter_if.slave  bus
);
    localparam int NUM_LANES = 4;

    typedef enum logic {IDLE, GRANT} state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 7) begin : g_bad_hold
        $error("MAX_HOLD must be in 1..7");
    end

    state_t                         r_state;
    logic [1:0]                     r_ptr;
    logic [1:0]                     r_sel;
    logic [NUM_LANES-1:0]           r_gnt;
    logic [WIDTH-1:0]               r_out_data;
    logic                           r_out_valid;

    logic [NUM_LANES-1:0][WIDTH-1:0] w_lane;
    logic                           w_found;
    logic [1:0]                     w_pick;
    logic                           w_slot_free;
    logic                           w_req_sel;
    logic                           w_accept;
    logic                           w_hold_hit;
    logic                           w_release;

    assign w_lane = bus.din;

    // Search starts one past the last owner so the previous winner ends up lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = 1; k <= NUM_LANES; k++) begin
            if (!w_found && bus.req[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_pick  = r_ptr + 2'(k);
            end
        end
    end

    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_req_sel   = bus.req[r_sel];
    assign w_accept    = (r_state == GRANT) && w_req_sel && w_slot_free;
    assign w_release   = (r_state == GRANT) &&
                         (!w_req_sel || (w_accept && (bus.last[r_sel] || w_hold_hit)));

`ifdef MUX_ARB_HOLD_LIMIT_EN
    logic [2:0] r_hold;

    assign w_hold_hit = (r_hold + 3'd1) == 3'(MAX_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_hold <= 3'd0;
        else if (w_release)
            r_hold <= 3'd0;
        else if (w_accept)
            r_hold <= r_hold + 3'd1;
    end
`else
    assign w_hold_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= 2'd3;
            r_sel       <= 2'd0;
            r_gnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Output stage drains independently of arbitration state.
            if (w_accept) begin
                r_out_data  <= w_lane[r_sel];
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt   <= 4'b0001 << w_pick;
                        r_sel   <= w_pick;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_gnt   <= '0;
                        r_ptr   <= r_sel;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.sel       = r_sel;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter.
module tb_mux_arbiter;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mux_arbiter_if #(.WIDTH(16)) bus ();

    mux_arbiter #(.WIDTH(16), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_lane(input int i, input logic [15:0] v);
        bus.din[i*16 +: 16] = v;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus.req = '0;
        bus.last = '0;
        bus.din = '0;
        bus.out_ready = 1'b1;

        // Reset takes effect without a clock edge
        #2 rst_n = 1'b0;
        bus.req = 4'hF;
        #1;
        chk("rst_gnt",   32'(bus.gnt), 32'h0);
        chk("rst_sel",   32'(bus.sel), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_data",  32'(bus.out_data), 32'h0);
        bus.req = '0;
        tick();
        rst_n = 1'b1;

        // Single burst on requester 2
        bus.req = 4'b0100;
        bus.last = 4'b0100;
        set_lane(2, 16'hA5A5);
        tick();
        chk("sb_gnt",   32'(bus.gnt), 32'h4);
        chk("sb_sel",   32'(bus.sel), 32'h2);
        chk("sb_valid0", 32'(bus.out_valid), 32'h0);
        tick();
        chk("sb_data",  32'(bus.out_data), 32'hA5A5);
        chk("sb_valid", 32'(bus.out_valid), 32'h1);
        chk("sb_rel",   32'(bus.gnt), 32'h0);
        chk("sb_selkeep", 32'(bus.sel), 32'h2);
        bus.req = '0;
        tick();
        chk("sb_drain", 32'(bus.out_valid), 32'h0);

        // Fairness: all four requesting, single-beat bursts
        do_reset();
        bus.last = 4'hF;
        for (int i = 0; i < 4; i++) set_lane(i, 16'(16'h1111 * i));
        bus.req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("fair_gnt", 32'(bus.gnt), 32'(4'b0001 << (k % 4)));
            tick();
            chk("fair_data", 32'(bus.out_data), 32'(16'h1111 * (k % 4)));
            chk("fair_valid", 32'(bus.out_valid), 32'h1);
            chk("fair_bubble", 32'(bus.gnt), 32'h0);
        end
        bus.req = '0;
        tick();

        // Hold limit: requester 0 never marks last
        do_reset();
        bus.req = 4'b0011;
        bus.last = '0;
        tick();
        chk("hl_gnt0", 32'(bus.gnt), 32'h1);
        for (int b = 0; b < 4; b++) begin
            set_lane(0, 16'(16'hA000 + b));
            tick();
            chk("hl_data", 32'(bus.out_data), 32'(16'hA000 + b));
`ifdef MUX_ARB_HOLD_LIMIT_EN
            chk("hl_gnt", 32'(bus.gnt), (b == 3) ? 32'h0 : 32'h1);
`else
            chk("hl_gnt", 32'(bus.gnt), 32'h1);
`endif
        end
        set_lane(0, 16'hA004);
        tick();
`ifdef MUX_ARB_HOLD_LIMIT_EN
        chk("hl_next", 32'(bus.gnt), 32'h2);
`else
        chk("hl_next", 32'(bus.gnt), 32'h1);
        chk("hl_beat5", 32'(bus.out_data), 32'hA004);
`endif
        bus.req = '0;
        tick();
        tick();

        // Backpressure mid-burst on requester 2
        do_reset();
        bus.req = 4'b0100;
        bus.last = '0;
        tick();
        chk("bp_gnt", 32'(bus.gnt), 32'h4);
        set_lane(2, 16'h0001);
        tick();
        chk("bp_d1", 32'(bus.out_data), 32'h0001);
        set_lane(2, 16'h0002);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_hold_data",  32'(bus.out_data), 32'h0001);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
            chk("bp_hold_gnt",   32'(bus.gnt), 32'h4);
            chk("bp_hold_sel",   32'(bus.sel), 32'h2);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_d2", 32'(bus.out_data), 32'h0002);
        chk("bp_v2", 32'(bus.out_valid), 32'h1);
        set_lane(2, 16'h0003);
        bus.last = 4'b0100;
        tick();
        chk("bp_d3", 32'(bus.out_data), 32'h0003);
        chk("bp_rel", 32'(bus.gnt), 32'h0);

        // Reset in the middle of a burst
        bus.last = '0;
        tick();
        chk("mr_gnt", 32'(bus.gnt), 32'h4);
        set_lane(2, 16'h0004);
        tick();
        chk("mr_data", 32'(bus.out_data), 32'h0004);
        chk("mr_valid", 32'(bus.out_valid), 32'h1);
        chk("mr_gnt_hold", 32'(bus.gnt), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_rst_gnt",   32'(bus.gnt), 32'h0);
        chk("mr_rst_sel",   32'(bus.sel), 32'h0);
        chk("mr_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mr_rst_data",  32'(bus.out_data), 32'h0);
        bus.req = 4'hF;
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_first", 32'(bus.gnt), 32'h1);
        chk("mr_first_sel", 32'(bus.sel), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
